// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing definitions: default word width and
// the kernel feeder state encoding.
package hdc_pkg;

  localparam int HV_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4,
    REPORT    = 3'd5
  } kernel_feeder_state_t;

endpackage

// File: rtl/kernel_feeder.sv
// Streams word_count hypervector words from a synchronous source RAM into a
// kernel over a valid/ready handshake, then waits for the kernel result.
module kernel_feeder
  import hdc_pkg::*;
#(
  parameter int HV_DATA_WIDTH = HV_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH    = 13,
  parameter int DONE_TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [ADDR_WIDTH:0]      word_count,
  output logic                     busy,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [HV_DATA_WIDTH-1:0] mem_rd_data,
  output logic                     k_valid,
  output logic                     k_first,
  output logic                     k_last,
  output logic [HV_DATA_WIDTH-1:0] k_data,
  input  logic                     k_ready,
  input  logic                     k_done,
  input  logic [HV_DATA_WIDTH-1:0] k_result,
  output logic                     result_valid,
  output logic [HV_DATA_WIDTH-1:0] result_data,
  output logic                     err_timeout,
  output logic                     err_empty
);

  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(DONE_TIMEOUT - 1);

  kernel_feeder_state_t state;
  logic [ADDR_WIDTH:0]  remaining;
  logic                 first_word;
  logic [TW-1:0]        wait_cnt;

  // mem_addr doubles as the running word address for the whole job.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      k_valid      <= 1'b0;
      k_first      <= 1'b0;
      k_last       <= 1'b0;
      k_data       <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      err_timeout  <= 1'b0;
      err_empty    <= 1'b0;
      remaining    <= '0;
      first_word   <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_timeout <= 1'b0;
            err_empty   <= 1'b0;
            mem_addr    <= base_addr;
            remaining   <= word_count;
            first_word  <= 1'b1;
            busy        <= 1'b1;
            if (word_count == '0) begin
              err_empty <= 1'b1;
              state     <= REPORT;
            end else begin
              mem_rd_en <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          mem_rd_en <= 1'b0;
          state     <= LOAD;
        end
        LOAD: begin
          k_data  <= mem_rd_data;
          k_valid <= 1'b1;
          k_first <= first_word;
          k_last  <= (remaining == (ADDR_WIDTH+1)'(1));
          state   <= SEND;
        end
        SEND: begin
          if (k_ready) begin
            k_valid    <= 1'b0;
            k_first    <= 1'b0;
            k_last     <= 1'b0;
            first_word <= 1'b0;
            if (k_last) begin
              wait_cnt <= '0;
              state    <= WAIT_DONE;
            end else begin
              mem_addr  <= mem_addr + ADDR_WIDTH'(1);
              remaining <= remaining - (ADDR_WIDTH+1)'(1);
              mem_rd_en <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        WAIT_DONE: begin
          if (k_done) begin
            result_data <= k_result;
            state       <= REPORT;
          end else if (wait_cnt == WAIT_LAST) begin
            err_timeout <= 1'b1;
            state       <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        REPORT: begin
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_feeder.sv
// Directed and randomized jobs against a word-list reference model of the
// feeder, with a synchronous-read RAM model as the source memory.
module tb_kernel_feeder;
  localparam int HW = 32;
  localparam int AW = 13;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          busy;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [HW-1:0] mem_rd_data;
  logic          k_valid;
  logic          k_first;
  logic          k_last;
  logic [HW-1:0] k_data;
  logic          k_ready;
  logic          k_done;
  logic [HW-1:0] k_result;
  logic          result_valid;
  logic [HW-1:0] result_data;
  logic          err_timeout;
  logic          err_empty;

  kernel_feeder #(
    .HV_DATA_WIDTH(HW),
    .ADDR_WIDTH(AW),
    .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .word_count(word_count),
    .busy(busy),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .k_valid(k_valid),
    .k_first(k_first),
    .k_last(k_last),
    .k_data(k_data),
    .k_ready(k_ready),
    .k_done(k_done),
    .k_result(k_result),
    .result_valid(result_valid),
    .result_data(result_data),
    .err_timeout(err_timeout),
    .err_empty(err_empty)
  );

  always #5 clk = ~clk;

  logic [HW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  int            checks;
  int            errors;
  logic [HW-1:0] exp_result;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, 64'({busy, mem_rd_en, k_valid, k_first, k_last,
                               result_valid, err_timeout, err_empty}), 64'(0));
    check({tag, "_data"}, 64'({k_data, mem_addr}), 64'(0));
    check({tag, "_result"}, 64'(result_data), 64'(0));
  endtask

  // rmode: 0 ready always, 1 ready toggles, 2 ready random.
  // d: WAIT_DONE cycle on which k_done is raised (>= TO means never).
  // abort_reads: if nonzero, reset is applied once that many reads were seen.
  task automatic run_job(input logic [AW-1:0] base, input int n, input int rmode,
                         input int d, input logic [HW-1:0] res, input int abort_reads);
    logic [HW+1:0] obs_q[$];
    logic [AW-1:0] rd_q[$];
    logic [HW+1:0] hold;
    logic [HW+1:0] exp_word;
    logic [AW-1:0] a;
    int            wstart;
    int            rv_cyc;
    int            valid_cnt;
    int            exp_lat;
    int            lasts;
    bit            finished;
    bit            stalled;
    bit            aborting;
    logic [1:0]    exp_flags;

    wstart = -1; rv_cyc = 0; valid_cnt = 0; lasts = 0;
    finished = 0; stalled = 0; aborting = 0; hold = '0;

    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = (AW+1)'(n); k_done = 1'b0; k_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~base;

    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clk);
      if (aborting) begin
        check_reset_values("abort_reset");
        reset_n  = 1'b1;
        finished = 1;
      end else begin
        case (rmode)
          0:       k_ready = 1'b1;
          1:       k_ready = ~k_ready;
          default: k_ready = 1'($urandom_range(0, 1));
        endcase
        if (wstart >= 0) begin
          k_done   = (cyc - wstart - 1 == d);
          k_result = (cyc - wstart - 1 == d) ? res : HW'($urandom);
        end else begin
          k_done   = 1'($urandom_range(0, 1));
          k_result = HW'($urandom);
        end

        if (cyc == 1)
          check("flags_clear", 64'({err_timeout, err_empty}), 64'({1'b0, (n == 0)}));
        if (mem_rd_en) rd_q.push_back(mem_addr);
        if (k_valid) valid_cnt++;
        if (stalled)
          check("stall_hold", 64'({k_valid, k_first, k_last, k_data}), 64'({1'b1, hold}));
        stalled = k_valid && !k_ready;
        hold    = {k_first, k_last, k_data};
        if (k_valid && k_ready) begin
          obs_q.push_back({k_first, k_last, k_data});
          if (obs_q.size() == n) wstart = cyc;
        end
        if (result_valid) begin
          rv_cyc   = cyc;
          finished = 1;
        end else begin
          check("busy", 64'(busy), 64'(1));
        end
        if (abort_reads > 0 && rd_q.size() == abort_reads) begin
          reset_n  = 1'b0;
          aborting = 1;
        end
        start = (!finished && n > 0 && wstart < 0 && !aborting) ?
                1'($urandom_range(0, 3) == 0) : 1'b0;
        base_addr = AW'($urandom);
      end
    end
    start = 1'b0;
    if (!finished) check("job_done", 64'(0), 64'(1));

    if (abort_reads > 0) begin
      exp_result = '0;
      check("abort_reads", 64'(rd_q.size()), 64'(abort_reads));
      for (int i = 0; i < rd_q.size(); i++) begin
        a = base + AW'(i);
        check($sformatf("abort_addr%0d", i), 64'(rd_q[i]), 64'(a));
      end
      foreach (obs_q[i]) if (obs_q[i][HW]) lasts++;
      check("abort_no_last", 64'(lasts), 64'(0));
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("abort_quiet", 64'({result_valid, k_valid, busy}), 64'(0));
      end
    end else begin
      check("xfer_count", 64'(obs_q.size()), 64'(n));
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
        a = base + AW'(i);
        exp_word = {(i == 0), (i == n - 1), ram[a]};
        check($sformatf("xfer%0d", i), 64'(obs_q[i]), 64'(exp_word));
      end
      check("read_count", 64'(rd_q.size()), 64'(n));
      for (int i = 0; i < n && i < rd_q.size(); i++) begin
        a = base + AW'(i);
        check($sformatf("read_addr%0d", i), 64'(rd_q[i]), 64'(a));
      end
      if (n == 0) begin
        check("empty_no_valid", 64'(valid_cnt), 64'(0));
        exp_flags = 2'b01;
        exp_lat   = 2;
      end else if (d < TO) begin
        exp_result = res;
        exp_flags  = 2'b00;
        exp_lat    = 3 * n + d + 3;
      end else begin
        exp_flags = 2'b10;
        exp_lat   = 3 * n + TO + 2;
      end
      check("err_flags", 64'({err_timeout, err_empty}), 64'(exp_flags));
      check("result_data", 64'(result_data), 64'(exp_result));
      if (rmode == 0) check("latency", 64'(rv_cyc), 64'(exp_lat));
      @(negedge clk);
      check("rv_pulse", 64'(result_valid), 64'(0));
      k_done = 1'b0;
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_result = '0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    k_ready = 1'b0; k_done = 1'b0; k_result = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = HW'($urandom);
    for (int i = 0; i < 4; i++) ram[16 + i] = HW'(i + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_job(13'h010, 4, 0, 2, 32'd24, 0);
    run_job(AW'($urandom), 1, 0, 0, HW'($urandom), 0);
    run_job(AW'($urandom), 5, 1, 3, HW'($urandom), 0);
    run_job(AW'($urandom), 0, 0, 0, HW'($urandom), 0);
    run_job(AW'($urandom), 2, 0, 100, HW'($urandom), 0);
    run_job(13'h1FFE, 3, 0, 1, HW'($urandom), 0);
    for (int j = 0; j < 5; j++)
      run_job(AW'($urandom), $urandom_range(1, 6), $urandom_range(0, 2),
              $urandom_range(0, 9), HW'($urandom), 0);
    run_job(13'h1FFE, 3, 0, 1, HW'($urandom), 2);
    run_job(AW'($urandom), 2, 2, 0, HW'($urandom), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
